gray_track_decoder: RTL and testbench
=====================================

// Module: gray_track_decoder
// PURPOSE
//  Downstream stage of the 4-bit binary->Gray encoder: consumes a 4-bit reflected Gray position
//  code (e.g. absolute encoder disk or encoder output crossing a boundary), synchronizes it,
//  decodes to binary, tracks step direction and whole revolutions, flags illegal multi-step jumps.
//  Feeds position/revolution data to the display/control logic.
// PARAMETERS
//  SYNC_STAGES  2  flops in Ngray input synchronizer; 0 = bypass (input already on clock)
//  REV_W        8  width of signed revolution counter
//  ERR_W        4  width of saturating jump-error counter
// PORTS
//  clock      in   1       single clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  Ngray      in   4       Gray-coded position, may be asynchronous to clock
//  sample_en  in   1       on-clock qualifier; decode stage updates only when 1
//  clear_err  in   1       on-clock; clears err_cnt
//  Nbin       out  4       registered decoded binary position
//  valid      out  1       1 once first sample taken after reset
//  step       out  1       one-cycle pulse: legal +/-1 move accepted
//  dir_up     out  1       direction of last legal step (1 = increment); held between steps
//  err        out  1       one-cycle pulse: |delta| > 1 detected
//  revs       out  REV_W   signed revolution count, two's complement
//  err_cnt    out  ERR_W   saturating count of err pulses
// BEHAVIOUR
//  Reset (reset=1 at an edge): sync flops, Nbin, revs, err_cnt <= 0; valid, step, err, dir_up <= 0;
//   FSM <= INIT. Reset has priority over every other input; mid-operation reset discards history.
//  Decode: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0 (combinational on synchronized code gs).
//  Latency: Ngray stable before edge k -> gs valid after edge k+SYNC_STAGES-1; with sample_en=1 at
//   edge k+SYNC_STAGES, outputs reflect it after that edge (SYNC_STAGES+1 edges total).
//  FSM INIT: on sample_en: Nbin<=decoded, valid<=1, -> TRACK; no step/err/revs change.
//  FSM TRACK: on sample_en, d = (decoded - Nbin) mod 16:
//   d=0  : no change, step=0, err=0.
//   d=1  : Nbin<=decoded, step=1, dir_up<=1; if Nbin==15 (wrap 15->0) revs<=revs+1.
//   d=15 : Nbin<=decoded, step=1, dir_up<=0; if Nbin==0 (wrap 0->15) revs<=revs-1.
//   else : Nbin<=decoded (resync), err=1, dir_up/revs unchanged, err_cnt+1 saturating at all-ones.
//  sample_en=0: all registers hold; step/err deassert.
//  revs wraps modulo 2^REV_W on overflow (no saturation).
//  clear_err=1: err_cnt<=0; wins over simultaneous increment (err pulse still emitted).
//  step and err never both 1. No other FSM states; INIT re-entered only via reset.
// STRUCTURE
//  Package gray_pkg: localparam GRAY_W=4; function gray2bin(4-bit); typedef enum {INIT,TRACK}.
//  Sub-module gray_sync #(.W(4),.STAGES(SYNC_STAGES)): plain flop chain, reset to 0, generate
//   bypass when STAGES=0. Decode, delta compare, FSM, counters stay in top module.
// TESTING (SYNC_STAGES=2, REV_W=8, ERR_W=4, sample_en=1 unless stated)
//  1 reset, Ngray=4'b0110 -> after 3 edges Nbin=4, valid=1, step=0, revs=0, err=0.
//  2 from Nbin=14 apply Gray 15 (1000) then 0 (0000) -> two step pulses, dir_up=1, revs=1, Nbin=0.
//  3 from Nbin=0 apply Gray 15 (1000) -> step, dir_up=0, revs=-1 (8'hFF), Nbin=15.
//  4 from Nbin=3 apply Gray 6 (0101) -> err pulse, Nbin=6, err_cnt=1, revs/dir_up unchanged;
//    17 such jumps -> err_cnt=15; clear_err with jump same cycle -> err_cnt=0, err=1.
//  5 sample_en=0 while Ngray changes -> outputs hold; reassert -> single update/err per d rule.
//  6 reset asserted mid-rotation with revs=5 -> next edge all outputs 0, FSM INIT, first sample
//    after release sets valid with no step.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray position tracker: code width, FSM states and the Gray->binary decode.
package gray_pkg;
  localparam int GRAY_W = 4;

  typedef enum logic {INIT, TRACK} state_t;

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus; only one bit changes per move, so a bus chain is safe.
// Latency STAGES edges (0 = combinational bypass); no backpressure.
module gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [W-1:0] sr [STAGES];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[STAGES-1];
  end
endmodule

// File: rtl/gray_track_decoder.sv
// Synchronizes and decodes a Gray position, tracks direction/revolutions and flags multi-step jumps.
// Latency SYNC_STAGES+1 edges from Ngray to outputs; sample_en=0 freezes the decode stage.
module gray_track_decoder
  import gray_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REV_W       = 8,
  parameter int ERR_W       = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [GRAY_W-1:0]       Ngray,
  input  logic                    sample_en,
  input  logic                    clear_err,
  output logic [GRAY_W-1:0]       Nbin,
  output logic                    valid,
  output logic                    step,
  output logic                    dir_up,
  output logic                    err,
  output logic signed [REV_W-1:0] revs,
  output logic [ERR_W-1:0]        err_cnt
);
  logic [GRAY_W-1:0] gs, decoded, delta;
  state_t            state, state_nxt;
  logic [GRAY_W-1:0] nbin_nxt;
  logic              valid_nxt, step_nxt, dir_nxt, err_nxt;
  logic signed [REV_W-1:0] revs_nxt;
  logic [ERR_W-1:0]  errcnt_nxt;

  gray_sync #(.W(GRAY_W), .STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (Ngray),
    .q     (gs)
  );

  assign decoded = gray2bin(gs);
  assign delta   = decoded - Nbin;  // modulo-16 move since the last accepted sample

  always_comb begin
    state_nxt  = state;
    nbin_nxt   = Nbin;
    valid_nxt  = valid;
    step_nxt   = 1'b0;
    err_nxt    = 1'b0;
    dir_nxt    = dir_up;
    revs_nxt   = revs;
    errcnt_nxt = err_cnt;

    if (sample_en) begin
      case (state)
        INIT: begin
          nbin_nxt  = decoded;
          valid_nxt = 1'b1;
          state_nxt = TRACK;
        end
        TRACK: begin
          case (delta)
            4'd0: ;
            4'd1: begin
              nbin_nxt = decoded;
              step_nxt = 1'b1;
              dir_nxt  = 1'b1;
              if (Nbin == 4'hF) revs_nxt = revs + REV_W'(1);
            end
            4'd15: begin
              nbin_nxt = decoded;
              step_nxt = 1'b1;
              dir_nxt  = 1'b0;
              if (Nbin == 4'h0) revs_nxt = revs - REV_W'(1);
            end
            default: begin
              nbin_nxt = decoded;
              err_nxt  = 1'b1;
            end
          endcase
        end
        default: state_nxt = INIT;
      endcase
    end

    // Clearing wins over a same-cycle jump; the err pulse itself still goes out.
    if (clear_err)                       errcnt_nxt = '0;
    else if (err_nxt && (err_cnt != '1)) errcnt_nxt = err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= INIT;
      Nbin    <= '0;
      valid   <= 1'b0;
      step    <= 1'b0;
      dir_up  <= 1'b0;
      err     <= 1'b0;
      revs    <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      Nbin    <= nbin_nxt;
      valid   <= valid_nxt;
      step    <= step_nxt;
      dir_up  <= dir_nxt;
      err     <= err_nxt;
      revs    <= revs_nxt;
      err_cnt <= errcnt_nxt;
    end
  end
endmodule

// File: tb/tb_gray_track_decoder.sv
// Bench for gray_track_decoder: directed scenarios plus random walks against an absolute-position model.
module tb_gray_track_decoder;
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        Ngray = '0;
  logic              sample_en = 1'b1;
  logic              clear_err = 1'b0;
  logic [3:0]        Nbin;
  logic              valid, step, dir_up, err;
  logic signed [7:0] revs;
  logic [3:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute position as an unbounded integer; Nbin/revs are derived from it.
  logic [3:0] p1, p2;
  int         m_abs, m_errcnt;
  bit         m_valid, m_step, m_err, m_dir;
  logic [3:0] e_nbin;
  logic [7:0] e_revs;

  gray_track_decoder #(.SYNC_STAGES(2), .REV_W(8), .ERR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .Ngray     (Ngray),
    .sample_en (sample_en),
    .clear_err (clear_err),
    .Nbin      (Nbin),
    .valid     (valid),
    .step      (step),
    .dir_up    (dir_up),
    .err       (err),
    .revs      (revs),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [3:0] g);
    int b = 0;
    for (int i = 0; i < 4; i++) if (^(g >> i)) b += (1 << i);
    return b;
  endfunction

  task automatic tick();
    logic [3:0] gs;
    int bin, dl;
    @(posedge clock);
    if (reset) begin
      p1 = '0; p2 = '0; m_abs = 0; m_errcnt = 0;
      m_valid = 0; m_step = 0; m_err = 0; m_dir = 0;
    end else begin
      gs = p2; p2 = p1; p1 = Ngray;
      m_step = 0; m_err = 0;
      if (sample_en) begin
        bin = from_gray(gs);
        if (!m_valid) begin
          m_abs = bin; m_valid = 1;
        end else begin
          dl = (bin - (m_abs & 15) + 16) % 16;
          if (dl == 1)       begin m_abs += 1; m_step = 1; m_dir = 1; end
          else if (dl == 15) begin m_abs -= 1; m_step = 1; m_dir = 0; end
          else if (dl != 0)  begin m_abs = (m_abs & ~15) + bin; m_err = 1; end
        end
      end
      if (clear_err) m_errcnt = 0;
      else if (m_err && m_errcnt < 15) m_errcnt++;
    end
    e_nbin = 4'(m_abs & 15);
    e_revs = 8'(m_abs >>> 4);
    #1;
  endtask

  // Reset, then prime the synchronizer with Ngray=g so the next tick's INIT sample sees g.
  task automatic restart(input logic [3:0] g);
    reset = 1'b1; Ngray = g; sample_en = 1'b1; clear_err = 1'b0;
    tick();
    reset = 1'b0; sample_en = 1'b0;
    tick(); tick();
    sample_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Ngray = 4'b0110; sample_en = 1'b1;
    tick();
    checks++; if (Nbin !== 4'd0 || valid !== 1'b0 || step !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL reset_flags got nbin=%0d valid=%b step=%b err=%b exp 0/0/0/0", Nbin, valid, step, err); end
    checks++; if (revs !== 8'sd0 || err_cnt !== 4'd0 || dir_up !== 1'b0)
      begin errors++; $display("FAIL reset_counts got revs=%0d errcnt=%0d dir=%b exp 0/0/0", revs, err_cnt, dir_up); end
    reset = 1'b0; sample_en = 1'b0;
    tick(); tick();
    sample_en = 1'b1;
    tick();
    checks++; if (Nbin !== 4'd4 || valid !== 1'b1)
      begin errors++; $display("FAIL first_sample got nbin=%0d valid=%b exp 4/1", Nbin, valid); end
    checks++; if (step !== 1'b0 || err !== 1'b0 || revs !== 8'sd0)
      begin errors++; $display("FAIL first_sample_quiet got step=%b err=%b revs=%0d exp 0/0/0", step, err, revs); end
  endtask

  task automatic test_wrap_up();
    int steps = 0;
    restart(to_gray(14));
    tick();
    Ngray = to_gray(15); tick(); steps += step;
    Ngray = to_gray(0);
    for (int i = 0; i < 3; i++) begin
      tick(); steps += step;
      checks++; if (step !== m_step)
        begin errors++; $display("FAIL wrap_up_step t%0d got %b exp %b", i, step, m_step); end
    end
    checks++; if (steps != 2)
      begin errors++; $display("FAIL wrap_up_pulses got %0d exp 2", steps); end
    checks++; if (Nbin !== 4'd0 || revs !== 8'sd1 || dir_up !== 1'b1)
      begin errors++; $display("FAIL wrap_up_final got nbin=%0d revs=%0d dir=%b exp 0/1/1", Nbin, revs, dir_up); end
  endtask

  task automatic test_wrap_down();
    restart(to_gray(0));
    tick();
    Ngray = 4'b1000;
    tick(); tick(); tick();
    checks++; if (step !== 1'b1 || dir_up !== 1'b0)
      begin errors++; $display("FAIL wrap_down_step got step=%b dir=%b exp 1/0", step, dir_up); end
    checks++; if (revs !== 8'shFF || Nbin !== 4'd15)
      begin errors++; $display("FAIL wrap_down_final got revs=%h nbin=%0d exp ff/15", revs, Nbin); end
  endtask

  task automatic test_jump();
    restart(to_gray(3));
    tick();
    Ngray = 4'b0101;
    tick(); tick(); tick();
    checks++; if (err !== 1'b1 || step !== 1'b0 || Nbin !== 4'd6 || err_cnt !== 4'd1)
      begin errors++; $display("FAIL jump_first got err=%b step=%b nbin=%0d cnt=%0d exp 1/0/6/1", err, step, Nbin, err_cnt); end
    checks++; if (revs !== 8'sd0 || dir_up !== 1'b0)
      begin errors++; $display("FAIL jump_keep got revs=%0d dir=%b exp 0/0", revs, dir_up); end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) Ngray = to_gray((i % 2 == 0) ? 3 : 6);
      tick();
      checks++; if (err !== m_err || err_cnt !== 4'(m_errcnt))
        begin errors++; $display("FAIL jump_run t%0d got err=%b cnt=%0d exp %b/%0d", i, err, err_cnt, m_err, m_errcnt); end
    end
    checks++; if (err_cnt !== 4'd15)
      begin errors++; $display("FAIL jump_saturate got %0d exp 15", err_cnt); end
    Ngray = to_gray(3);
    tick(); tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (err !== 1'b1 || err_cnt !== 4'd0)
      begin errors++; $display("FAIL clear_vs_jump got err=%b cnt=%0d exp 1/0", err, err_cnt); end
  endtask

  task automatic test_hold();
    logic [3:0] s_nbin, x;
    logic [7:0] s_revs;
    logic [3:0] s_cnt;
    int events = 0;
    s_nbin = Nbin; s_revs = revs; s_cnt = err_cnt;
    x = 4'(Nbin + 4'd5);
    sample_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Ngray = (i < 3) ? 4'($urandom_range(0, 15)) : to_gray(x);
      tick();
      checks++; if (Nbin !== s_nbin || revs !== s_revs || err_cnt !== s_cnt || step !== 1'b0 || err !== 1'b0)
        begin errors++; $display("FAIL hold t%0d got nbin=%0d revs=%0d cnt=%0d step=%b err=%b exp %0d/%0d/%0d/0/0",
                                 i, Nbin, revs, err_cnt, step, err, s_nbin, s_revs, s_cnt); end
    end
    sample_en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); events += step + err; end
    checks++; if (events != 1 || Nbin !== x || err_cnt !== 4'(s_cnt + 4'd1))
      begin errors++; $display("FAIL hold_release got events=%0d nbin=%0d cnt=%0d exp 1/%0d/%0d", events, Nbin, err_cnt, x, s_cnt + 4'd1); end
  endtask

  task automatic test_random();
    int pos = 0;
    restart(to_gray(0));
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 12) pos = $urandom_range(0, 15);
      else pos = (pos + $urandom_range(0, 2) + 15) % 16;
      Ngray     = to_gray(pos);
      sample_en = ($urandom_range(0, 9) < 8);
      clear_err = ($urandom_range(0, 19) == 0);
      tick();
      checks++; if (Nbin !== e_nbin || revs !== e_revs || valid !== m_valid)
        begin errors++; $display("FAIL rand_pos c%0d got nbin=%0d revs=%0d valid=%b exp %0d/%0d/%b", c, Nbin, revs, valid, e_nbin, e_revs, m_valid); end
      checks++; if (step !== m_step || err !== m_err || dir_up !== m_dir || err_cnt !== 4'(m_errcnt))
        begin errors++; $display("FAIL rand_flags c%0d got step=%b err=%b dir=%b cnt=%0d exp %b/%b/%b/%0d",
                                 c, step, err, dir_up, err_cnt, m_step, m_err, m_dir, m_errcnt); end
    end
    clear_err = 1'b0; sample_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    restart(to_gray(0));
    tick();
    for (int i = 1; i <= 85; i++) begin Ngray = to_gray(i); tick(); end
    tick(); tick();
    checks++; if (revs !== 8'sd5 || Nbin !== 4'd5 || revs !== e_revs)
      begin errors++; $display("FAIL spin_up got revs=%0d nbin=%0d exp 5/5", revs, Nbin); end
    Ngray = to_gray(86);
    reset = 1'b1;
    tick();
    checks++; if (Nbin !== 4'd0 || revs !== 8'sd0 || valid !== 1'b0 || step !== 1'b0 || dir_up !== 1'b0 || err !== 1'b0 || err_cnt !== 4'd0)
      begin errors++; $display("FAIL mid_reset got nbin=%0d revs=%0d valid=%b step=%b dir=%b err=%b cnt=%0d exp all 0",
                               Nbin, revs, valid, step, dir_up, err, err_cnt); end
    reset = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || step !== 1'b0 || err !== 1'b0 || Nbin !== e_nbin)
      begin errors++; $display("FAIL reinit got valid=%b step=%b err=%b nbin=%0d exp 1/0/0/%0d", valid, step, err, Nbin, e_nbin); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_jump();
    test_hold();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
